aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller: accepts one 128-bit block, applies the initial key whitening,
//  then sequences NR rounds through an external round datapath (SubBytes/ShiftRows/MixColumns) over a req/ack handshake.
//  Applies the round-key XOR itself after each returned round and holds a loadable round-key bank.
//  Sits between the block-level stream interface and the shared round datapath.
// PARAMETERS
//  NR      10   number of rounds; round-key bank holds NR+1 keys
//  DATA_W  128  state/key width; fixed for AES, exposed for the bench only
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  key_we      in   1       round-key write strobe
//  key_idx     in   4       round-key index 0..NR
//  key_wdata   in   128     round-key value
//  key_err     out  1       1-cycle pulse: rejected key write
//  in_valid    in   1       input block valid
//  in_ready    out  1       controller can accept a block
//  in_data     in   128     plaintext block
//  out_valid   out  1       ciphertext valid
//  out_ready   in   1       consumer accepts ciphertext
//  out_data    out  128     ciphertext block
//  rnd_req     out  1       round request to datapath
//  rnd_state   out  128     state presented to datapath
//  rnd_last    out  1       final round: datapath bypasses MixColumns
//  rnd_ack     in   1       datapath result valid (may be same cycle as rnd_req)
//  rnd_result  in   128     datapath output, before key XOR
//  busy        out  1       1 in ROUND or DONE
// BEHAVIOUR
//  Reset: state IDLE, round=0, state_reg=0, all key entries=0; in_ready=1; out_valid, rnd_req, key_err, busy=0.
//  FSM: IDLE -> ROUND on in_valid&in_ready; ROUND -> DONE on rnd_ack when round==NR; DONE -> IDLE on out_ready.
//  Accept edge: state_reg <= in_data ^ rk[0]; round <= 1.
//  ROUND: rnd_req=1, rnd_state=state_reg, rnd_last=(round==NR); payload stable until rnd_ack.
//   On rnd_req&rnd_ack: state_reg <= rnd_result ^ rk[round]; round <= round+1 (or hold at NR on final).
//  DONE: out_valid=1, out_data=state_reg, stable until out_ready; on handshake round<=0.
//  in_ready = (state==IDLE); no overlap of blocks; combinational path in_valid->in_ready is forbidden.
//  Latency with zero-wait datapath (rnd_ack tied 1): accept at edge T, out_valid high in cycle T+NR+1 (T+11).
//  Each datapath wait cycle adds exactly one cycle; rnd_ack outside ROUND is ignored.
//  Key writes: accepted only when state==IDLE and key_idx<=NR; write lands next edge.
//   Write with busy=1 or key_idx>NR: bank unchanged, key_err pulses next cycle.
//   Write in the same cycle as an input accept: the write is accepted; the accept uses the pre-write rk[0].
//  Round counter: 4 bits, never exceeds NR; no wrap.
//  Reset asserted mid-block: immediate return to reset values; in-flight block is dropped, no out_valid.
// STRUCTURE
//  Shared package aes_pkg: AES_NR=10, AES_W=128, state enum {S_IDLE,S_ROUND,S_DONE}, typedef for the 128-bit block.
//  One sub-module: aes_round_key_bank (NR+1 x 128 regs, 1 write port, 2 async read ports: rk[0], rk[round]).
//  The key XOR stays inline in the sequencer; the FSM and counter stay in the top module.
// TESTING
//  FIPS-197 C.1: key 000102..0f expanded by bench into bank, pt 00112233445566778899aabbccddeeff, ack tied 1
//   -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a at cycle T+11.
//  Same vector, random 0-3 cycle ack delay per round -> same ciphertext; rnd_state/rnd_last stable while req&!ack;
//   rnd_last=1 only on round 10.
//  out_ready held 0 for 5 cycles -> out_valid/out_data hold; in_ready=0; second in_valid not accepted until the
//   out handshake completes.
//  key_we during ROUND, and key_idx=11 in IDLE -> key_err pulse each; bank unchanged; next block still gives 69c4...
//  rst_n low at round 5 -> in_ready=1, out_valid=0 next cycle; no stale output; following block correct.
//  Back-to-back blocks with out_ready=1 -> one block per NR+2 cycles; ciphertexts match reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 round sequencer:
//   - round count and block width
//   - width of the round counter / round-key index
//   - controller state encoding
//   - 128-bit block type
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR    = 10;   // AES-128 round count
  localparam int AES_W     = 128;  // state / key width
  localparam int AES_IDX_W = 4;    // round counter and key index width

  typedef logic [AES_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } aes_state_e;

endpackage : aes_pkg

// File: rtl/aes_round_key_bank.sv
// ---------------------------------------------------------------------------
// aes_round_key_bank
// Register bank holding the NR+1 round keys of one AES-128 key schedule.
// One synchronous write port, two asynchronous read ports: a fixed port for
// the whitening key rk[0] and an indexed port for the current round key.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every key)
//   we           write strobe (already qualified by the sequencer)
//   widx         write index 0..NR
//   wdata        key value to store
//   ridx         read index for rk_sel
//   rk0          always rk[0]
//   rk_sel       rk[ridx]; zero for an index beyond NR
// ---------------------------------------------------------------------------
module aes_round_key_bank
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int W  = AES_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AES_IDX_W-1:0] widx,
  input  logic [W-1:0]         wdata,
  input  logic [AES_IDX_W-1:0] ridx,
  output logic [W-1:0]         rk0,
  output logic [W-1:0]         rk_sel
);

  logic [W-1:0] key_arr [NR+1];

  // One register per key so each entry has a single driver.
  generate
    for (genvar gi = 0; gi <= NR; gi++) begin : gen_key
      logic [W-1:0] key_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          key_q <= '0;
        end else if (we && (widx == AES_IDX_W'(gi))) begin
          key_q <= wdata;
        end
      end

      assign key_arr[gi] = key_q;
    end
  endgenerate

  assign rk0 = key_arr[0];

  always_comb begin
    rk_sel = '0;
    for (int i = 0; i <= NR; i++) begin
      if (ridx == AES_IDX_W'(i)) begin
        rk_sel = key_arr[i];
      end
    end
  end

endmodule : aes_round_key_bank

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES-128 encryption controller. Accepts one plaintext block,
// whitens it with rk[0], then drives NR rounds through an external round
// datapath over rnd_req/rnd_ack, XORing the returned state with rk[round]
// after each round. The finished ciphertext is held on out_data until the
// consumer takes it. Only one block is in flight at a time.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_we/key_idx/key_wdata   round-key write (IDLE only, idx 0..NR)
//   key_err                    one-cycle pulse after a rejected key write
//   in_valid/in_ready/in_data  plaintext input handshake
//   out_valid/out_ready/out_data ciphertext output handshake
//   rnd_req/rnd_state/rnd_last round request to datapath (last: no MixColumns)
//   rnd_ack/rnd_result         datapath response, result before key XOR
//   busy                       high while a block is in flight (ROUND/DONE)
// ---------------------------------------------------------------------------
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int DATA_W = AES_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_we,
  input  logic [AES_IDX_W-1:0] key_idx,
  input  logic [DATA_W-1:0]    key_wdata,
  output logic                 key_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 rnd_req,
  output logic [DATA_W-1:0]    rnd_state,
  output logic                 rnd_last,
  input  logic                 rnd_ack,
  input  logic [DATA_W-1:0]    rnd_result,
  output logic                 busy
);

  localparam logic [AES_IDX_W-1:0] LAST_RND = AES_IDX_W'(NR);

  aes_state_e           state_q;
  logic [AES_IDX_W-1:0] round_q, round_d;
  logic [DATA_W-1:0]    blk_q, blk_d;
  logic                 key_err_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 rnd_req_q;
  logic                 busy_q;

  logic [DATA_W-1:0]    rk0;
  logic [DATA_W-1:0]    rk_sel;

  logic accept;
  logic rnd_fire;
  logic out_fire;
  logic final_rnd;
  logic key_ok;

  // in_ready_q is a pure function of state, so accept never feeds back into
  // in_ready combinationally.
  assign accept    = in_valid & in_ready_q;
  assign rnd_fire  = rnd_req_q & rnd_ack;   // ack without a request is ignored
  assign out_fire  = out_valid_q & out_ready;
  assign final_rnd = (round_q == LAST_RND);

  // Key writes only land while idle. A write coinciding with an accept is
  // still taken; the accept already sampled the old rk[0] this cycle.
  assign key_ok = key_we & (state_q == S_IDLE) & (key_idx <= LAST_RND);

  aes_round_key_bank #(
    .NR (NR),
    .W  (DATA_W)
  ) u_key_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (key_ok),
    .widx   (key_idx),
    .wdata  (key_wdata),
    .ridx   (round_q),
    .rk0    (rk0),
    .rk_sel (rk_sel)
  );

  // State register / round counter next values, including the key XORs.
  always_comb begin
    blk_d   = blk_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          blk_d   = in_data ^ rk0;
          round_d = AES_IDX_W'(1);
        end
      end
      S_ROUND: begin
        if (rnd_fire) begin
          blk_d = rnd_result ^ rk_sel;
          // Counter saturates at NR; it is cleared on the output handshake.
          if (!final_rnd) begin
            round_d = round_q + AES_IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (out_fire) begin
          round_d = '0;
        end
      end
      default: begin
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      blk_q       <= '0;
      key_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rnd_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      blk_q     <= blk_d;
      round_q   <= round_d;
      key_err_q <= key_we & ~key_ok;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= S_ROUND;
            in_ready_q <= 1'b0;
            rnd_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_ROUND: begin
          if (rnd_fire && final_rnd) begin
            state_q     <= S_DONE;
            rnd_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_fire) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          rnd_req_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign key_err   = key_err_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = blk_q;
  assign rnd_req   = rnd_req_q;
  assign rnd_state = blk_q;
  assign rnd_last  = rnd_req_q & final_rnd;
  assign busy      = busy_q;

endmodule : aes_round_sequencer

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int NR = AES_NR;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_we;
  logic [3:0]   key_idx;
  logic [127:0] key_wdata;
  logic         key_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         rnd_req;
  logic [127:0] rnd_state;
  logic         rnd_last;
  logic         rnd_ack;
  logic [127:0] rnd_result;
  logic         busy;

  aes_round_sequencer #(.NR(NR), .DATA_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_we     (key_we),
    .key_idx    (key_idx),
    .key_wdata  (key_wdata),
    .key_err    (key_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rnd_req    (rnd_req),
    .rnd_state  (rnd_state),
    .rnd_last   (rnd_last),
    .rnd_ack    (rnd_ack),
    .rnd_result (rnd_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int out_cnt = 0;
  int ack_mode = 0;      // 0: ack tied high, 1: random 0..3 wait cycles
  int acc_cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rk_model[NR+1];

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);   // accumulates x^254 = multiplicative inverse
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns; byte k = row k%4, col k/4.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] a[16];
    logic [7:0] b[16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) a[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c+0] = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
      for (int k = 0; k < 16; k++) b[k] = a[k];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[k];
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_model[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, r == NR) ^ rk_model[r];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    failed++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // ---------------- round datapath responder ----------------
  initial begin : responder
    int wait_left;
    int rcnt;
    logic hold_pend;
    logic go;
    logic [127:0] held_state;
    logic held_last;
    wait_left = -1;
    rcnt = 0;
    hold_pend = 1'b0;
    held_state = '0;
    held_last = 1'b0;
    rnd_ack = 1'b0;
    rnd_result = '0;
    forever begin
      @(negedge clk);
      rnd_result = aes_round(rnd_state, rnd_last);
      if (!rst_n || !rnd_req) begin
        rnd_ack   = (ack_mode == 0);
        wait_left = -1;
        hold_pend = 1'b0;
        rcnt      = 0;
      end else begin
        if (hold_pend) begin
          check("rnd_state_hold", rnd_state, held_state);
          check("rnd_last_hold", 128'(rnd_last), 128'(held_last));
        end
        check("rnd_last", 128'(rnd_last), 128'(rcnt == NR - 1));
        if (ack_mode == 0) begin
          go = 1'b1;
        end else begin
          if (wait_left < 0) wait_left = $urandom_range(0, 3);
          if (wait_left == 0) go = 1'b1;
          else begin
            go = 1'b0;
            wait_left--;
          end
        end
        rnd_ack = go;
        if (go) begin
          rcnt++;
          hold_pend = 1'b0;
          wait_left = -1;
        end else begin
          hold_pend  = 1'b1;
          held_state = rnd_state;
          held_last  = rnd_last;
        end
      end
    end
  end

  // ---------------- output scoreboard ----------------
  initial begin : out_monitor
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          failed++;
          $error("FAIL unexpected_output: observed %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
        end
        $display("out block %0d: %h", out_cnt, out_data);
        out_cnt++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus tasks ----------------
  task automatic load_keys();
    for (int r = 0; r <= NR; r++) begin
      @(posedge clk); #1;
      key_we = 1'b1;
      key_idx = 4'(r);
      key_wdata = rk_model[r];
    end
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    check("key_err_on_valid_load", 128'(key_err), 128'(0));
  endtask

  // Drives one block and returns one step after the accepting edge.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] exp);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = pt;
    exp_q.push_back(exp);
    $display("in block: %h", pt);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("accept_timeout");
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain_timeout");
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    int prev;
    int cnt_snap;
    logic [127:0] pt;

    rst_n = 1'b0;
    key_we = 1'b0;
    key_idx = '0;
    key_wdata = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_rnd_req", 128'(rnd_req), 128'(0));
    check("rst_key_err", 128'(key_err), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    expand_key(FIPS_KEY);
    load_keys();

    // FIPS-197 C.1 with zero-wait datapath: latency and busy flags
    ack_mode = 0;
    send_block(FIPS_PT, FIPS_CT);
    @(negedge clk);
    check("busy_in_round", 128'(busy), 128'(1));
    check("in_ready_in_round", 128'(in_ready), 128'(0));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("out_valid_timeout");
    check("latency", 128'(cyc - acc_cyc), 128'(11));
    wait_drain();

    // Same vector with random datapath wait states
    ack_mode = 1;
    send_block(FIPS_PT, FIPS_CT);
    wait_drain();

    // Output backpressure, second block held off
    ack_mode = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_block(FIPS_PT, FIPS_CT);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout_fail("bp_out_valid_timeout");
    @(posedge clk); #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    in_data = pt;
    exp_q.push_back(aes_encrypt(pt));
    $display("in block: %h", pt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, FIPS_CT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("bp_accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Rejected key writes: while busy, and out-of-range index while idle
    ack_mode = 1;
    send_block(FIPS_PT, FIPS_CT);
    key_we = 1'b1;
    key_idx = 4'd10;
    key_wdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    check("key_err_busy", 128'(key_err), 128'(1));
    @(negedge clk);
    check("key_err_pulse_end", 128'(key_err), 128'(0));
    wait_drain();
    @(posedge clk); #1;
    key_we = 1'b1;
    key_idx = 4'd11;
    key_wdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    key_we = 1'b0;
    @(negedge clk);
    check("key_err_idx11", 128'(key_err), 128'(1));
    ack_mode = 0;
    send_block(FIPS_PT, FIPS_CT);
    wait_drain();

    // Reset mid-block drops the block and clears the key bank
    send_block(FIPS_PT, FIPS_CT);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_rnd_req", 128'(rnd_req), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_snap = out_cnt;
    load_keys();
    repeat (15) @(negedge clk);
    check("no_stale_output", 128'(out_cnt), 128'(cnt_snap));
    send_block(FIPS_PT, FIPS_CT);
    wait_drain();

    // Back-to-back blocks: one accept every NR+2 cycles
    ack_mode = 0;
    out_ready = 1'b1;
    prev = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      in_data = pt;
      exp_q.push_back(aes_encrypt(pt));
      $display("in block: %h", pt);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) timeout_fail("b2b_accept_timeout");
      if (i > 0) check("b2b_spacing", 128'(cyc - prev), 128'(NR + 2));
      prev = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_aes_round_sequencer
